// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
package pmem_arb_pkg;

  localparam int unsigned PMEM_ADDR_W = 32;
  localparam int unsigned PMEM_LINE_W = 256;
  localparam int unsigned PMEM_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the L1 I-cache and D-cache.
// One line transaction at a time; command is latched at grant and held until pmem_resp.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = PMEM_ADDR_W,
  parameter int unsigned LINE_W = PMEM_LINE_W,
  parameter int unsigned CNT_W  = PMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  i_grant_count,
  output logic [CNT_W-1:0]  d_grant_count
);

  arb_state_t        state_q,   state_d;
  requester_t        rr_last_q, rr_last_d;
  logic              read_q,    read_d;
  logic              write_q,   write_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LINE_W-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0]  i_cnt_q,   i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q,   d_cnt_d;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  // Tie goes to whichever side was not served last.
  always_comb begin
    req_i   = i_pmem_read;
    req_d   = d_pmem_read | d_pmem_write;
    grant_i = req_i & (~req_d | (rr_last_q == REQ_D));
    grant_d = req_d & ~grant_i;
  end

  // next_state_logic: state transitions, command latching and grant counting.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    read_d    = read_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d   = GNT_I;
          rr_last_d = REQ_I;
          read_d    = 1'b1;
          write_d   = 1'b0;
          addr_d    = i_pmem_address;
          wdata_d   = '0;
          i_cnt_d   = (i_cnt_q == '1) ? i_cnt_q : i_cnt_q + CNT_W'(1);
        end else if (grant_d) begin
          // A read+write collision is illegal; the write-back is honoured.
          state_d   = GNT_D;
          rr_last_d = REQ_D;
          read_d    = ~d_pmem_write;
          write_d   = d_pmem_write;
          addr_d    = d_pmem_address;
          wdata_d   = d_pmem_wdata;
          d_cnt_d   = (d_cnt_q == '1) ? d_cnt_q : d_cnt_q + CNT_W'(1);
        end
      end
      GNT_I, GNT_D: begin
        // Memory cannot be aborted, so strobes hold until it answers.
        if (pmem_resp) begin
          state_d = RELEASE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // state_actions: route the memory response to the granted side only.
  always_comb begin
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    unique case (state_q)
      GNT_I: begin
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_rdata;
      end
      GNT_D: begin
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_rdata;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_last_q <= REQ_D;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  assign pmem_read     = read_q;
  assign pmem_write    = write_q;
  assign pmem_address  = addr_q;
  assign pmem_wdata    = wdata_q;
  assign i_grant_count = i_cnt_q;
  assign d_grant_count = d_cnt_q;

`ifndef SYNTHESIS
  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(d_pmem_read && d_pmem_write));
  a_strobe_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read && pmem_write));
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter: reset, lone grants, ties, alternation, write-back, reset abort.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [CNT_W-1:0]  i_grant_count;
  logic [CNT_W-1:0]  d_grant_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .i_grant_count  (i_grant_count),
    .d_grant_count  (d_grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst            = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Plays memory for one granted transaction (entered just after the grant edge,
  // returns just after the edge into RELEASE) and records what the arbiter showed.
  task automatic mem_xfer(input int lat, input logic [LINE_W-1:0] rd,
                          output logic rd_s, output logic wr_s,
                          output logic [ADDR_W-1:0] addr_s, output logic [LINE_W-1:0] wd_s,
                          output logic stable, output logic iresp, output logic dresp,
                          output logic [LINE_W-1:0] irdata, output logic [LINE_W-1:0] drdata);
    stable = 1'b1;
    rd_s = 1'b0; wr_s = 1'b0; addr_s = '0; wd_s = '0;
    iresp = 1'b0; dresp = 1'b0; irdata = '0; drdata = '0;
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
      end
      @(negedge clk);
      if (c == 1) begin
        rd_s = pmem_read; wr_s = pmem_write; addr_s = pmem_address; wd_s = pmem_wdata;
      end else if (pmem_read !== rd_s || pmem_write !== wr_s ||
                   pmem_address !== addr_s || pmem_wdata !== wd_s) begin
        stable = 1'b0;
      end
      if (c < lat && (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0)) stable = 1'b0;
      if (c == lat) begin
        iresp = i_pmem_resp; dresp = d_pmem_resp; irdata = i_pmem_rdata; drdata = d_pmem_rdata;
      end
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    i_pmem_read  = 1'b1;
    d_pmem_read  = 1'b1;
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b1;
    pmem_rdata   = {LINE_W{1'b1}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec_cnt++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 ||
          pmem_address !== '0 || pmem_wdata !== '0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
        err_cnt++;
        $display("FAIL reset_outputs cycle %0d: strobes/resps=%b addr=%h exp all zero", c,
                 {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address);
      end
    end
    vec_cnt++;
    if (i_grant_count !== '0 || d_grant_count !== '0) begin
      err_cnt++;
      $display("FAIL reset_counters: got %0d/%0d exp 0/0", i_grant_count, d_grant_count);
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic test_lone_i();
    logic rd_s, wr_s, stable, iresp, dresp;
    logic [ADDR_W-1:0] addr_s;
    logic [LINE_W-1:0] wd_s, irdata, drdata, exp_rd;
    exp_rd = {32{8'hA5}};
    reset_dut();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0) begin
      err_cnt++;
      $display("FAIL lone_i_latency: pmem_read=%b before grant edge exp 0", pmem_read);
    end
    tick();
    mem_xfer(5, exp_rd, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
    i_pmem_read = 1'b0;
    vec_cnt++;
    if (rd_s !== 1'b1 || wr_s !== 1'b0 || addr_s !== 32'h0000_1000 || stable !== 1'b1) begin
      err_cnt++;
      $display("FAIL lone_i_cmd: rd=%b wr=%b addr=%h stable=%b exp 1 0 00001000 1",
               rd_s, wr_s, addr_s, stable);
    end
    vec_cnt++;
    if (iresp !== 1'b1 || dresp !== 1'b0 || irdata !== exp_rd || drdata !== '0) begin
      err_cnt++;
      $display("FAIL lone_i_resp: iresp=%b dresp=%b irdata=%h exp 1 0 %h", iresp, dresp, irdata, exp_rd);
    end
    vec_cnt++;
    if (i_grant_count !== 32'd1 || d_grant_count !== 32'd0) begin
      err_cnt++;
      $display("FAIL lone_i_count: got %0d/%0d exp 1/0", i_grant_count, d_grant_count);
    end
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      err_cnt++;
      $display("FAIL lone_i_release: rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_tie();
    logic rd_s, wr_s, stable, iresp, dresp;
    logic [ADDR_W-1:0] addr_s;
    logic [LINE_W-1:0] wd_s, irdata, drdata, w;
    w = {8{32'hDEAD_0200}};
    reset_dut();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0100;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0200;
    d_pmem_wdata   = w;
    tick();
    mem_xfer(3, {LINE_W{1'b0}} | 256'h1111, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
    i_pmem_read = 1'b0;
    vec_cnt++;
    if (rd_s !== 1'b1 || wr_s !== 1'b0 || addr_s !== 32'h0000_0100 || iresp !== 1'b1 || dresp !== 1'b0) begin
      err_cnt++;
      $display("FAIL tie_first_i: rd=%b wr=%b addr=%h iresp=%b dresp=%b exp 1 0 00000100 1 0",
               rd_s, wr_s, addr_s, iresp, dresp);
    end
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin
      err_cnt++;
      $display("FAIL tie_release: rd=%b wr=%b dresp=%b exp 0 0 0", pmem_read, pmem_write, d_pmem_resp);
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      err_cnt++;
      $display("FAIL tie_idle_gap: rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
    tick();
    mem_xfer(2, '0, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
    d_pmem_write = 1'b0;
    vec_cnt++;
    if (rd_s !== 1'b0 || wr_s !== 1'b1 || addr_s !== 32'h0000_0200 || wd_s !== w || stable !== 1'b1) begin
      err_cnt++;
      $display("FAIL tie_second_d: rd=%b wr=%b addr=%h stable=%b wdata=%h exp 0 1 00000200 1 %h",
               rd_s, wr_s, addr_s, stable, wd_s, w);
    end
    vec_cnt++;
    if (dresp !== 1'b1 || iresp !== 1'b0 || i_grant_count !== 32'd1 || d_grant_count !== 32'd1) begin
      err_cnt++;
      $display("FAIL tie_d_resp: dresp=%b iresp=%b cnt=%0d/%0d exp 1 0 1/1",
               dresp, iresp, i_grant_count, d_grant_count);
    end
  endtask

  task automatic test_back_to_back();
    logic rd_s, wr_s, stable, iresp, dresp;
    logic [ADDR_W-1:0] addr_s, exp_addr;
    logic [LINE_W-1:0] wd_s, irdata, drdata;
    logic exp_i;
    reset_dut();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1100;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_2200;
    tick();
    for (int k = 0; k < 8; k++) begin
      mem_xfer(1 + (k % 3), '0, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
      exp_i    = (k % 2 == 0);
      exp_addr = exp_i ? 32'h0000_1100 : 32'h0000_2200;
      vec_cnt++;
      if (addr_s !== exp_addr || rd_s !== 1'b1 || iresp !== exp_i || dresp !== !exp_i || stable !== 1'b1) begin
        err_cnt++;
        $display("FAIL alternate_grant %0d: addr=%h iresp=%b dresp=%b exp addr=%h iresp=%b",
                 k, addr_s, iresp, dresp, exp_addr, exp_i);
      end
      if (k == 7) begin
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
      end
      tick();
      tick();
    end
    vec_cnt++;
    if (i_grant_count !== 32'd4 || d_grant_count !== 32'd4) begin
      err_cnt++;
      $display("FAIL alternate_counts: got %0d/%0d exp 4/4", i_grant_count, d_grant_count);
    end
  endtask

  task automatic test_writeback();
    logic rd_s, wr_s, stable, iresp, dresp;
    logic [ADDR_W-1:0] addr_s;
    logic [LINE_W-1:0] wd_s, irdata, drdata, w1, rd;
    w1 = {16{16'hC3_5A}};
    rd = {8{32'h0400_BEEF}};
    reset_dut();
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0300;
    d_pmem_wdata   = w1;
    tick();
    d_pmem_wdata = ~w1;
    mem_xfer(4, '0, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
    d_pmem_write   = 1'b0;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0400;
    vec_cnt++;
    if (wr_s !== 1'b1 || rd_s !== 1'b0 || addr_s !== 32'h0000_0300 || wd_s !== w1 ||
        stable !== 1'b1 || dresp !== 1'b1) begin
      err_cnt++;
      $display("FAIL wb_write: wr=%b rd=%b addr=%h stable=%b dresp=%b wdata=%h exp 1 0 00000300 1 1 %h",
               wr_s, rd_s, addr_s, stable, dresp, wd_s, w1);
    end
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      err_cnt++;
      $display("FAIL wb_release: rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
    tick();
    tick();
    mem_xfer(2, rd, rd_s, wr_s, addr_s, wd_s, stable, iresp, dresp, irdata, drdata);
    d_pmem_read = 1'b0;
    vec_cnt++;
    if (rd_s !== 1'b1 || wr_s !== 1'b0 || addr_s !== 32'h0000_0400 || dresp !== 1'b1 || drdata !== rd) begin
      err_cnt++;
      $display("FAIL wb_read: rd=%b wr=%b addr=%h dresp=%b drdata=%h exp 1 0 00000400 1 %h",
               rd_s, wr_s, addr_s, dresp, drdata, rd);
    end
    vec_cnt++;
    if (i_grant_count !== 32'd0 || d_grant_count !== 32'd2) begin
      err_cnt++;
      $display("FAIL wb_counts: got %0d/%0d exp 0/2", i_grant_count, d_grant_count);
    end
  endtask

  task automatic test_reset_abort();
    reset_dut();
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0500;
    tick();
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0500 || d_grant_count !== 32'd1) begin
      err_cnt++;
      $display("FAIL abort_granted: rd=%b addr=%h dcnt=%0d exp 1 00000500 1",
               pmem_read, pmem_address, d_grant_count);
    end
    tick();
    rst         = 1'b0;
    d_pmem_read = 1'b0;
    tick();
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_address !== '0 || i_grant_count !== '0 || d_grant_count !== '0) begin
      err_cnt++;
      $display("FAIL abort_reset: rd=%b addr=%h cnt=%0d/%0d exp 0 00000000 0/0",
               pmem_read, pmem_address, i_grant_count, d_grant_count);
    end
    rst = 1'b1;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = {LINE_W{1'b1}};
    @(negedge clk);
    vec_cnt++;
    if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin
      err_cnt++;
      $display("FAIL abort_stale_resp: dresp=%b iresp=%b exp 0 0", d_pmem_resp, i_pmem_resp);
    end
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    vec_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_grant_count !== '0) begin
      err_cnt++;
      $display("FAIL abort_idle: rd=%b wr=%b dcnt=%0d exp 0 0 0", pmem_read, pmem_write, d_grant_count);
    end
  endtask

  initial begin
    rst            = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
    tick();
    test_reset();
    test_lone_i();
    test_tie();
    test_back_to_back();
    test_writeback();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
